// File: rtl/regfile_bist.sv
// regfile_bist: write/readback self-test for an attached register file (shifted all-ones patterns).
// Define REGFILE_BIST_PORT2_CHECK_EN to also verify read port 2 against the mirrored register index.
module regfile_bist #(
    parameter int WIDTH     = 32,
    parameter int NUMOFREGS = 32,
    localparam int AW       = $clog2(NUMOFREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW-1:0]    fail_reg,
    output logic             regWrite,
    output logic [AW-1:0]    wreg,
    output logic [WIDTH-1:0] wdata,
    output logic [AW-1:0]    rreg1,
    output logic [AW-1:0]    rreg2,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2
);
    localparam int          IW       = AW + 1;
    localparam logic [AW:0] LAST_IDX = IW'(NUMOFREGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [AW:0]     idx_q, idx_d;
    logic            pass_q, pass_d;
    logic [AW-1:0]   fail_reg_q, fail_reg_d;
    logic [AW-1:0]   mirror_idx;
    logic            mism1, mism2;

    function automatic logic [WIDTH-1:0] pat(input logic [AW:0] i);
        logic [WIDTH-1:0] ones;
        ones = '1;
        return ones >> i;
    endfunction

    // Register 0 reads back as zero regardless of what was written.
    function automatic logic [WIDTH-1:0] exp_val(input logic [AW:0] i);
        return (i == '0) ? '0 : pat(i);
    endfunction

    always_comb begin
        mirror_idx = AW'(NUMOFREGS - 1) - idx_q[AW-1:0];
        mism1      = (rdata1 != exp_val(idx_q));
    end

`ifdef REGFILE_BIST_PORT2_CHECK_EN
    always_comb begin
        mism2 = (rdata2 != exp_val({1'b0, mirror_idx}));
    end
`else
    logic unused_rdata2;
    always_comb begin
        mism2         = 1'b0;
        unused_rdata2 = ^rdata2;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            pass_q     <= 1'b0;
            fail_reg_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pass_q     <= pass_d;
            fail_reg_q <= fail_reg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pass_d     = pass_q;
        fail_reg_d = fail_reg_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_WRITE;
                    idx_d      = '0;
                    pass_d     = 1'b0;
                    fail_reg_d = '0;
                end
            end
            S_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_READ: begin
                // Port 1 wins when both ports mismatch in the same cycle.
                if (mism1) begin
                    pass_d     = 1'b0;
                    fail_reg_d = idx_q[AW-1:0];
                    state_d    = S_DONE;
                end else if (mism2) begin
                    pass_d     = 1'b0;
                    fail_reg_d = mirror_idx;
                    state_d    = S_DONE;
                end else if (idx_q == LAST_IDX) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        regWrite = 1'b0;
        wreg     = '0;
        wdata    = '0;
        rreg1    = '0;
        rreg2    = '0;
        pass     = pass_q;
        fail_reg = fail_reg_q;
        unique case (state_q)
            S_WRITE: begin
                busy     = 1'b1;
                regWrite = 1'b1;
                wreg     = idx_q[AW-1:0];
                wdata    = pat(idx_q);
            end
            S_READ: begin
                busy  = 1'b1;
                rreg1 = idx_q[AW-1:0];
                rreg2 = mirror_idx;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_regfile_bist.sv
// Randomized fault-injection bench for regfile_bist against a behavioural register-file and outcome model.
// Honours REGFILE_BIST_PORT2_CHECK_EN to predict the port-2 check.
module tb_regfile_bist;
    localparam int W      = 32;
    localparam int N      = 32;
    localparam int AW     = 5;
    localparam int BUDGET = 3 * N + 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy, done, pass, regWrite;
    logic [AW-1:0] fail_reg, wreg, rreg1, rreg2;
    logic [W-1:0]  wdata, rdata1, rdata2;

    logic [W-1:0]  mem    [N];
    logic [W-1:0]  stuck0 [N];
    logic          corrupt2;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_bist #(.WIDTH(W), .NUMOFREGS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_reg(fail_reg), .regWrite(regWrite), .wreg(wreg), .wdata(wdata),
        .rreg1(rreg1), .rreg2(rreg2), .rdata1(rdata1), .rdata2(rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file with stuck-at-0 bits, hardwired r0, optional port-2 corruption of the top register.
    always @(posedge clk) begin
        if (regWrite && wreg != '0) mem[wreg] <= wdata & ~stuck0[wreg];
    end
    assign rdata1 = (rreg1 == '0) ? '0 : mem[rreg1];
    assign rdata2 = ((rreg2 == '0) ? '0 : mem[rreg2]) ^
                    ((corrupt2 && rreg2 == AW'(N - 1)) ? W'(1) : '0);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pat_model(input int i);
        longint unsigned full;
        if (i >= W) return '0;
        full = (64'd1 << (W - i)) - 64'd1;
        return full[W-1:0];
    endfunction

    function automatic logic [W-1:0] exp_model(input int i);
        return (i == 0) ? '0 : pat_model(i);
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, pass, fail_reg, regWrite, wreg, wdata, rreg1, rreg2});
    endfunction

    task automatic clear_faults();
        for (int r = 0; r < N; r++) stuck0[r] = '0;
        corrupt2 = 1'b0;
    endtask

    // Outcome from the fault set: first read step whose value differs from the expected pattern.
    task automatic predict(output bit p, output int freg, output int step);
        logic [W-1:0] stored [N];
`ifdef REGFILE_BIST_PORT2_CHECK_EN
        int           m;
        logic [W-1:0] v;
`endif
        p    = 1'b1;
        freg = 0;
        step = N - 1;
        for (int r = 0; r < N; r++) stored[r] = (r == 0) ? '0 : (pat_model(r) & ~stuck0[r]);
        for (int i = 0; i < N; i++) begin
            if (stored[i] != exp_model(i)) begin
                p = 1'b0; freg = i; step = i;
                return;
            end
`ifdef REGFILE_BIST_PORT2_CHECK_EN
            m = N - 1 - i;
            v = stored[m] ^ ((corrupt2 && m == N - 1) ? W'(1) : '0);
            if (v != exp_model(m)) begin
                p = 1'b0; freg = m; step = i;
                return;
            end
`endif
        end
    endtask

    // Must be entered just after a falling edge; leaves at a falling edge.
    task automatic do_run(input string name, input bit hold_start);
        bit exp_pass;
        int exp_freg, exp_step, exp_done_c, got_done_c;
        int write_errs, read_errs, rd;
        predict(exp_pass, exp_freg, exp_step);
        exp_done_c = N + 1 + exp_step;
        write_errs = 0;
        read_errs  = 0;
        got_done_c = -1;
        start = 1'b1;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (c == 0) begin
                check_eq({name, "_launch_clear"}, 64'({pass, fail_reg}), 64'd0);
                if (!hold_start) start = 1'b0;
            end
            if (c < N) begin
                if (regWrite !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || wreg !== AW'(c) ||
                    wdata !== pat_model(c) || rreg1 !== '0 || rreg2 !== '0) write_errs++;
            end else if (done === 1'b1) begin
                got_done_c = c;
                break;
            end else begin
                rd = c - N;
                if (regWrite !== 1'b0 || busy !== 1'b1 || wreg !== '0 || wdata !== '0 ||
                    rreg1 !== AW'(rd) || rreg2 !== AW'(N - 1 - rd)) read_errs++;
            end
        end
        check_eq({name, "_done_cycle"}, 64'(got_done_c), 64'(exp_done_c));
        check_eq({name, "_pass"}, 64'(pass), 64'(exp_pass));
        check_eq({name, "_fail_reg"}, 64'(fail_reg), 64'(exp_freg));
        check_eq({name, "_busy_in_done"}, 64'(busy), 64'd0);
        check_eq({name, "_write_seq_errs"}, 64'(write_errs), 64'd0);
        check_eq({name, "_read_seq_errs"}, 64'(read_errs), 64'd0);
        @(negedge clk);
        check_eq({name, "_after_done"}, 64'({done, busy, pass, fail_reg}),
                 64'({2'b00, exp_pass, AW'(exp_freg)}));
        if (hold_start) begin
            @(negedge clk);
            check_eq({name, "_restart"}, 64'({busy, regWrite, wreg}), 64'({2'b11, AW'(0)}));
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        clear_faults();

        #2 rst = 1'b1;
        #1 check_eq("reset_async", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("idle_no_start", 64'({busy, done, regWrite}), 64'd0);
        end

        do_run("clean", 1'b0);

        stuck0[5] = W'(1);
        do_run("stuck_r5b0", 1'b0);
        clear_faults();

        do_run("hold_start", 1'b1);
        start = 1'b0;
        rst   = 1'b1;
        #1 check_eq("reset_abort_hold", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mid_write_idx", 64'({regWrite, wreg}), 64'({1'b1, AW'(10)}));
        rst = 1'b1;
        #1 check_eq("reset_mid_write", all_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_run("after_abort", 1'b0);

        corrupt2 = 1'b1;
        do_run("port2_r31", 1'b0);
        clear_faults();

        for (int it = 0; it < 6; it++) begin
            int kind, nfaults;
            clear_faults();
            kind    = int'($urandom_range(0, 2));
            nfaults = kind;
            for (int f = 0; f < nfaults; f++)
                stuck0[$urandom_range(1, N - 1)][$urandom_range(0, W - 1)] = 1'b1;
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_run($sformatf("rand%0d", it), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_bist.md
REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 Parameter WIDTH, default 32, data width of the attached register file.
REQ-002 Parameter NUMOFREGS, default 32, number of registers in the attached register file; AW = $clog2(NUMOFREGS).
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  level, sampled only in IDLE; launches one test run.
REQ-006 Port busy  output  1  high in WRITE and READ states.
REQ-007 Port done  output  1  one-cycle pulse marking run completion.
REQ-008 Port pass  output  1  run result; valid from done pulse until next run launches.
REQ-009 Port fail_reg  output  AW  index of first mismatching register; 0 when pass=1.
REQ-010 Port regWrite  output  1  register-file write enable.
REQ-011 Port wreg  output  AW  register-file write address.
REQ-012 Port wdata  output  WIDTH  register-file write data.
REQ-013 Port rreg1  output  AW  register-file read address, port 1.
REQ-014 Port rreg2  output  AW  register-file read address, port 2.
REQ-015 Port rdata1  input  WIDTH  register-file read data, port 1 (combinational read).
REQ-016 Port rdata2  input  WIDTH  register-file read data, port 2 (combinational read).

Function
REQ-017 FSM states IDLE, WRITE, READ, DONE; a single AW+1-bit index counter idx drives both phases.
REQ-018 IDLE: start=1 at edge -> WRITE, idx=0, pass=0, fail_reg=0; start=0 -> stay.
REQ-019 WRITE: regWrite=1, wreg=idx, wdata=PAT(idx); idx increments each cycle; after idx=NUMOFREGS-1 -> READ, idx=0.
REQ-020 PAT(i) = all-ones WIDTH-bit vector logically shifted right by i; PAT(i)=0 for i>=WIDTH.
REQ-021 READ: regWrite=0, rreg1=idx, rreg2=NUMOFREGS-1-idx; at each edge compare rdata1 against EXP(idx).
REQ-022 EXP(i) = 0 for i=0 (register 0 hardwired zero), else PAT(i).
REQ-023 First mismatch: fail_reg=index of failing register, pass=0, -> DONE immediately (remaining reads skipped).
REQ-024 No mismatch through idx=NUMOFREGS-1: pass=1, -> DONE.
REQ-025 DONE: done=1 for exactly one cycle, -> IDLE; pass/fail_reg hold.
REQ-026 Latency, clean run: start sampled at edge k -> done high in cycle after edge k+2*NUMOFREGS (WRITE NUMOFREGS cycles, READ NUMOFREGS cycles).
REQ-027 start while busy or in DONE: ignored; no restart, no effect on result.
REQ-028 Outside WRITE: regWrite=0, wreg=0, wdata=0; outside READ: rreg1=0, rreg2=0.
REQ-029 All outputs decode from registered state only; no combinational path from rdata1/rdata2/start to any output.

Reset
REQ-030 rst=1 forces IDLE, idx=0, busy=0, done=0, pass=0, fail_reg=0, regWrite=0, wreg=0, wdata=0, rreg1=0, rreg2=0, without waiting for clk.
REQ-031 rst mid-run aborts; register-file contents undefined; next start begins from idx=0.

Configuration
REQ-032 Macro REGFILE_BIST_PORT2_CHECK_EN defined: READ additionally compares rdata2 against EXP(NUMOFREGS-1-idx); port-1 mismatch takes priority in the same cycle; port-2 mismatch reports fail_reg=NUMOFREGS-1-idx.
REQ-033 Macro undefined: rdata2 ignored; rreg2 still driven per REQ-021.

Verification
REQ-034 Assert rst -> all outputs 0 with no clock edge; release, start=0 for 10 cycles -> stays IDLE, busy=0.
REQ-035 Defaults, correct regfile model, start pulse -> wreg 0..31 with wdata FFFFFFFF,7FFFFFFF,...,00000001; done 64 cycles after start edge; pass=1, fail_reg=0.
REQ-036 Model with register 5 bit 0 stuck-at-0 -> pass=0, fail_reg=5, done one cycle after READ idx=5 (READ aborted).
REQ-037 start held high throughout run -> exactly one run; new run only after DONE->IDLE with start sampled high.
REQ-038 rst pulse during WRITE at idx=10 -> regWrite=0 immediately; subsequent start repeats full run from wreg=0, pass=1.
REQ-039 Macro defined, port-2 read of register 31 corrupted -> pass=0, fail_reg=31 at READ idx=0; macro undefined, same stimulus -> pass=1.
